pr_queue_axi_drain: RTL and testbench
=====================================

Name: pr_queue_axi_drain

Overview:
- AXI-lite master at the far end of the core's PR-queue slave port (2-bit write address, 4-bit read address, 32-bit data) plus its pr_request_pending line.
- When pending is high, it reads the queue head, hands the request to the partial-reconfiguration controller, waits for that controller to finish, then writes a completion/pop word back to the core.
- Sits in the fabric shell between the Taiga core and the DFX/ICAP controller; only one request is in flight at a time.

Parameters:
- HEAD_RADDR, 4'h0, read address of the queue-head entry
- STATUS_RADDR, 4'h4, read address of the occupancy/status word; read only under PR_QUEUE_DRAIN_TIMEOUT_EN
- POP_WADDR, 2'h0, write address that pops the head and reports completion
- TIMEOUT_CYCLES, 65536, PR-controller watchdog limit; used only under PR_QUEUE_DRAIN_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pr_request_pending  in  1  core has at least one queued PR request
- m_axi_araddr  out  4  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- m_axi_awaddr  out  2  write address
- m_axi_awvalid  out  1  write address valid
- m_axi_awready  in  1  write address ready
- m_axi_wdata  out  32  write data
- m_axi_wvalid  out  1  write data valid
- m_axi_wready  in  1  write data ready
- m_axi_bvalid  in  1  write response valid
- m_axi_bready  out  1  write response ready
- pr_req_valid  out  1  request offered to the PR controller
- pr_req_ready  in  1  PR controller accepts the request
- pr_req_data  out  32  head entry, bits [30:0]
- pr_done  in  1  single-cycle pulse: reconfiguration finished
- pr_error  in  1  qualifies pr_done: reconfiguration failed
- drain_busy  out  1  FSM is not in IDLE
- drain_count  out  16  completed requests, wraps at 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE.
  - Outputs 0: all valid/ready outputs, pr_req_data, drain_count.
  - m_axi_araddr=HEAD_RADDR, m_axi_awaddr=POP_WADDR, m_axi_wdata=0.
  - Reset mid-transaction abandons the transaction; the slave is reset with the core.
- FSM states: IDLE, AR, R, DISPATCH, WAIT_DONE, AW_W, B.
- IDLE -> AR: the cycle after pr_request_pending is sampled high.
- AR: arvalid=1, held until arready. Then -> R with rready=1.
- R: on rvalid, rdata is registered into pr_req_data with bit 31 cleared.
  - rdata[31]=1 (valid entry) -> DISPATCH.
  - rdata[31]=0 (spurious or empty) -> IDLE with no write.
- DISPATCH: pr_req_valid=1 until pr_req_ready, then -> WAIT_DONE. Minimum latency, pending-high to pr_req_valid, is 3 cycles with zero-wait slave responses.
- WAIT_DONE: on a pr_done pulse, wdata={pr_error, 15'b0, pr_req_data[15:0]}, then -> AW_W.
- AW_W: awvalid and wvalid assert in the same cycle. Each deasserts independently on its own ready, including awready and wready arriving in different cycles. When both handshakes are complete -> B with bready=1.
- B: on bvalid, drain_count increments, then -> IDLE.
- One-cycle IDLE gap between requests; pending is re-sampled there.
- Handshake rules:
  - valid is never dropped before its ready.
  - Address and data are stable while valid is high.
  - rready and bready are high only in R and B.
- Simultaneous events:
  - pr_done arriving in DISPATCH, i.e. in the same cycle as pr_req_ready, is captured and moves directly to AW_W.
  - pr_done outside DISPATCH and WAIT_DONE is ignored.
  - pr_request_pending falling mid-sequence has no effect; the current request completes.
- drain_busy = (state != IDLE).

Optional Feature:
- Macro: PR_QUEUE_DRAIN_TIMEOUT_EN.
- Enabled:
  - A 32-bit watchdog counts cycles in WAIT_DONE. It resets on entry to WAIT_DONE.
  - On reaching TIMEOUT_CYCLES it forces completion: wdata[31]=1, wdata[30]=1 (timeout flag).
  - A sticky output drain_timeout (1 bit) sets at that point and clears only on reset.
  - IDLE first reads STATUS_RADDR. Its rdata[7:0] is the occupancy; zero skips the head read.
- Disabled: no watchdog, no drain_timeout port, no status read, wdata[30]=0.

Decomposition:
- Package pr_queue_pkg holds:
  - drain_state_t enum
  - PR_ENTRY_VALID_BIT=31
  - completion-word field positions: ERR=31, TIMEOUT=30, ID=[15:0]
  - default addresses
- Natural sub-module: pr_axil_write_channel. It sequences AW/W with independent valid drop and the B wait, and exposes start/done to the FSM.

Test Plan:
- Pending=1; slave zero-wait; rdata=0x8000_0012; PR ready immediately; pr_done 10 cycles later, pr_error=0 -> pr_req_data=0x0000_0012; one write to POP_WADDR with wdata=0x0000_0012; drain_count=1.
- rdata=0x0000_0007 (valid bit 0) -> no pr_req_valid, no AW/W; FSM back to IDLE; drain_count unchanged.
- awready 3 cycles after valid, wready 1 cycle after valid -> wvalid drops after 1 cycle, awvalid after 3; B waited; exactly one write completes.
- pr_done with pr_error=1, entry id 0x00A5 -> wdata=0x8000_00A5.
- rst_n low during WAIT_DONE -> all outputs return to reset values immediately; after release, pending=1 restarts from AR.
- With PR_QUEUE_DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=16, no pr_done -> after 16 cycles wdata=0xC000_00xx; drain_timeout=1 and stays 1.

Source files
------------

// File: rtl/pr_queue_pkg.sv
// Shared types and constants for the PR-queue drain master.
// The optional watchdog/status-read path is enabled with PR_QUEUE_DRAIN_TIMEOUT_EN.
package pr_queue_pkg;

   // Main drain sequence states.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_AR        = 3'd1,
      ST_R         = 3'd2,
      ST_DISPATCH  = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_AW_W      = 3'd5,
      ST_B         = 3'd6
   } drain_state_t;

   // Write-channel sequencer states.
   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2
   } wr_state_t;

   // Bit 31 of a queue-head entry marks it as a real request.
   localparam int PR_ENTRY_VALID_BIT = 31;

   // Completion/pop word layout.
   localparam int CW_ERR_BIT     = 31;
   localparam int CW_TIMEOUT_BIT = 30;
   localparam int CW_ID_MSB      = 15;
   localparam int CW_ID_LSB      = 0;

   // Default slave-port addresses and watchdog limit.
   localparam logic [3:0]  DEF_HEAD_RADDR     = 4'h0;
   localparam logic [3:0]  DEF_STATUS_RADDR   = 4'h4;
   localparam logic [1:0]  DEF_POP_WADDR      = 2'h0;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;

   // Builds the word written back to the core when a request completes.
   function automatic logic [31:0] completion_word(input logic        err,
                                                   input logic        tmo,
                                                   input logic [15:0] id);
      logic [31:0] w;
      w                       = '0;
      w[CW_ERR_BIT]           = err;
      w[CW_TIMEOUT_BIT]       = tmo;
      w[CW_ID_MSB:CW_ID_LSB]  = id;
      return w;
   endfunction

endpackage

// File: rtl/pr_axil_write_channel.sv
// AXI-lite write sequencer: raises AW and W together on start, drops each
// on its own ready, then waits for the B response.
//
// Handshake contract: a valid output stays high until the matching ready is
// sampled high on a rising edge; bready is high only while a response is awaited.
module pr_axil_write_channel
   import pr_queue_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic awready,
   input  logic wready,
   input  logic bvalid,
   output logic awvalid,
   output logic wvalid,
   output logic bready,
   output logic addr_data_done,
   output logic done
);

   wr_state_t state, next_state;
   logic      aw_open;
   logic      w_open;

   // A channel is still open after this cycle if its valid is not accepted now.
   assign aw_open = awvalid && !awready;
   assign w_open  = wvalid && !wready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WR_IDLE;
      else        state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         WR_IDLE: if (start)                next_state = WR_DATA;
         WR_DATA: if (!aw_open && !w_open)  next_state = WR_RESP;
         WR_RESP: if (bvalid)               next_state = WR_IDLE;
         default:                           next_state = WR_IDLE;
      endcase
   end

   // Handshake status outputs.
   always_comb begin
      bready         = (state == WR_RESP);
      addr_data_done = (state == WR_DATA) && !aw_open && !w_open;
      done           = (state == WR_RESP) && bvalid;
   end

   // AW and W valids rise together and fall independently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
      end else if (start) begin
         awvalid <= 1'b1;
         wvalid  <= 1'b1;
      end else begin
         if (awvalid && awready) awvalid <= 1'b0;
         if (wvalid && wready)   wvalid  <= 1'b0;
      end
   end

endmodule

// File: rtl/pr_queue_axi_drain.sv
// Drains the core's PR request queue over AXI-lite: read head, hand it to the
// PR controller, wait for completion, write the completion/pop word back.
// Optional watchdog and status-first read: define PR_QUEUE_DRAIN_TIMEOUT_EN.
//
// Handshake contract (all channels): valid is held until its ready is sampled
// high, address/data are stable while valid is high, and rready/bready are
// asserted only while the matching response is being waited for.
module pr_queue_axi_drain
   import pr_queue_pkg::*;
#(
   parameter logic [3:0]  HEAD_RADDR     = DEF_HEAD_RADDR,
   parameter logic [3:0]  STATUS_RADDR   = DEF_STATUS_RADDR,
   parameter logic [1:0]  POP_WADDR      = DEF_POP_WADDR,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pr_request_pending,
   output logic [3:0]         m_axi_araddr,
   output logic               m_axi_arvalid,
   input  logic               m_axi_arready,
   input  logic [31:0]        m_axi_rdata,
   input  logic               m_axi_rvalid,
   output logic               m_axi_rready,
   output logic [1:0]         m_axi_awaddr,
   output logic               m_axi_awvalid,
   input  logic               m_axi_awready,
   output logic [31:0]        m_axi_wdata,
   output logic               m_axi_wvalid,
   input  logic               m_axi_wready,
   input  logic               m_axi_bvalid,
   output logic               m_axi_bready,
   output logic               pr_req_valid,
   input  logic               pr_req_ready,
   output logic [31:0]        pr_req_data,
   input  logic               pr_done,
   input  logic               pr_error,
   output logic               drain_busy,
   output logic [15:0]        drain_count,
`ifdef PR_QUEUE_DRAIN_TIMEOUT_EN
   output logic               drain_timeout,
`endif
   output drain_state_t       dbg_state
);

   drain_state_t state, next_state;
   logic         head_phase;
   logic         wd_expire;
   logic         wr_start;
   logic         wr_addr_data_done;
   logic         wr_done;
   logic [31:0]  cw_next;

`ifdef PR_QUEUE_DRAIN_TIMEOUT_EN
   logic        status_phase;
   logic [31:0] wd_cnt;
   logic        drain_timeout_q;

   assign head_phase    = !status_phase;
   assign m_axi_araddr  = status_phase ? STATUS_RADDR : HEAD_RADDR;
   // pr_done in the same cycle wins over the watchdog.
   assign wd_expire     = (state == ST_WAIT_DONE) && !pr_done &&
                          (wd_cnt == TIMEOUT_CYCLES - 1);
   assign drain_timeout = drain_timeout_q;

   // Watchdog: restarts from zero each time WAIT_DONE is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     wd_cnt <= '0;
      else if (state != ST_WAIT_DONE) wd_cnt <= '0;
      else                            wd_cnt <= wd_cnt + 32'd1;
   end

   // Each drain pass reads the status word first; its response clears the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       status_phase <= 1'b0;
      else if (state == ST_IDLE && pr_request_pending)  status_phase <= 1'b1;
      else if (state == ST_R && m_axi_rvalid)           status_phase <= 1'b0;
   end

   // Sticky timeout indication, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         drain_timeout_q <= 1'b0;
      else if (wd_expire) drain_timeout_q <= 1'b1;
   end
`else
   logic unused_cfg;

   assign head_phase   = 1'b1;
   assign m_axi_araddr = HEAD_RADDR;
   assign wd_expire    = 1'b0;
   assign unused_cfg   = ^{STATUS_RADDR, TIMEOUT_CYCLES};
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:      if (pr_request_pending) next_state = ST_AR;
         ST_AR:        if (m_axi_arready)      next_state = ST_R;
         ST_R: begin
            if (m_axi_rvalid) begin
               if (!head_phase)
                  next_state = (m_axi_rdata[7:0] != 8'd0) ? ST_AR : ST_IDLE;
               else
                  next_state = m_axi_rdata[PR_ENTRY_VALID_BIT] ? ST_DISPATCH : ST_IDLE;
            end
         end
         ST_DISPATCH:  if (pr_req_ready) next_state = pr_done ? ST_AW_W : ST_WAIT_DONE;
         ST_WAIT_DONE: if (pr_done || wd_expire) next_state = ST_AW_W;
         ST_AW_W:      if (wr_addr_data_done) next_state = ST_B;
         ST_B:         if (wr_done)           next_state = ST_IDLE;
         default:                             next_state = ST_IDLE;
      endcase
   end

   // State-decoded outputs and the completion event.
   always_comb begin
      m_axi_arvalid = (state == ST_AR);
      m_axi_rready  = (state == ST_R);
      pr_req_valid  = (state == ST_DISPATCH);
      drain_busy    = (state != ST_IDLE);
      dbg_state     = state;
      // Completion is taken in DISPATCH only together with the request handshake.
      wr_start      = ((state == ST_DISPATCH) && pr_req_ready && pr_done) ||
                      ((state == ST_WAIT_DONE) && (pr_done || wd_expire));
      // A watchdog completion always reports failure.
      cw_next       = completion_word(pr_done ? pr_error : 1'b1, wd_expire,
                                      pr_req_data[CW_ID_MSB:CW_ID_LSB]);
   end

   assign m_axi_awaddr = POP_WADDR;

   // Datapath registers: captured head entry, completion word, drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_req_data <= '0;
         m_axi_wdata <= '0;
         drain_count <= '0;
      end else begin
         if (state == ST_R && m_axi_rvalid && head_phase)
            pr_req_data <= {1'b0, m_axi_rdata[30:0]};
         if (wr_start)
            m_axi_wdata <= cw_next;
         if (wr_done)
            drain_count <= drain_count + 16'd1;
      end
   end

   pr_axil_write_channel u_wr (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (wr_start),
      .awready        (m_axi_awready),
      .wready         (m_axi_wready),
      .bvalid         (m_axi_bvalid),
      .awvalid        (m_axi_awvalid),
      .wvalid         (m_axi_wvalid),
      .bready         (m_axi_bready),
      .addr_data_done (wr_addr_data_done),
      .done           (wr_done)
   );

endmodule

// File: tb/tb_pr_queue_axi_drain.sv
// Directed bench for pr_queue_axi_drain (default build).
`timescale 1ns/1ps
module tb_pr_queue_axi_drain;
   import pr_queue_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        pr_request_pending;
   logic [3:0]  m_axi_araddr;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic        m_axi_rvalid, m_axi_rready;
   logic [1:0]  m_axi_awaddr;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic        m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready;
   logic        pr_req_valid, pr_req_ready;
   logic [31:0] pr_req_data;
   logic        pr_done, pr_error;
   logic        drain_busy;
   logic [15:0] drain_count;
   drain_state_t dbg_state;
`ifdef PR_QUEUE_DRAIN_TIMEOUT_EN
   logic        drain_timeout;
`endif

   pr_queue_axi_drain dut (
      .clk(clk), .rst_n(rst_n), .pr_request_pending(pr_request_pending),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .pr_req_valid(pr_req_valid), .pr_req_ready(pr_req_ready), .pr_req_data(pr_req_data),
      .pr_done(pr_done), .pr_error(pr_error), .drain_busy(drain_busy), .drain_count(drain_count),
`ifdef PR_QUEUE_DRAIN_TIMEOUT_EN
      .drain_timeout(drain_timeout),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- slave / PR-controller models ----------------
   logic [31:0] rd_value;
   int          aw_delay, w_delay;
   int          aw_wait, w_wait;
   logic        aw_got, w_got;

   assign m_axi_awready = m_axi_awvalid && (aw_wait == aw_delay);
   assign m_axi_wready  = m_axi_wvalid && (w_wait == w_delay);

   // Read slave: data returned the cycle after the address handshake.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axi_rvalid <= 1'b0;
         m_axi_rdata  <= '0;
      end else if (m_axi_arvalid && m_axi_arready) begin
         m_axi_rvalid <= 1'b1;
         m_axi_rdata  <= rd_value;
      end else if (m_axi_rvalid && m_axi_rready) begin
         m_axi_rvalid <= 1'b0;
      end
   end

   // Write slave: programmable ready delays, response after both beats.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b0;
      end else begin
         aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
         w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
         if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
         if (m_axi_wvalid && m_axi_wready)   w_got  <= 1'b1;
         if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0;
         end else if (!m_axi_bvalid &&
                      (aw_got || (m_axi_awvalid && m_axi_awready)) &&
                      (w_got  || (m_axi_wvalid && m_axi_wready))) begin
            m_axi_bvalid <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int          ar_hs = 0, pv_cyc = 0, aw_cyc = 0, w_cyc = 0;
   int          aw_hs = 0, w_hs = 0, b_hs = 0;
   logic [1:0]  last_awaddr = '0;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];

   always @(posedge clk) begin
      if (m_axi_arvalid && m_axi_arready) ar_hs <= ar_hs + 1;
      if (pr_req_valid)                   pv_cyc <= pv_cyc + 1;
      if (m_axi_awvalid)                  aw_cyc <= aw_cyc + 1;
      if (m_axi_wvalid)                   w_cyc <= w_cyc + 1;
      if (m_axi_awvalid && m_axi_awready) begin
         aw_hs <= aw_hs + 1;
         last_awaddr <= m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
         w_hs <= w_hs + 1;
         obs_q.push_back(m_axi_wdata);
      end
      if (m_axi_bvalid && m_axi_bready) b_hs <= b_hs + 1;
   end

   int checks = 0;
   int errors = 0;

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pr_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pr_req_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_b(input int snap, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b_hs != snap) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_done(input logic err);
      pr_error = err;
      pr_done  = 1'b1;
      @(negedge clk);
      pr_done  = 1'b0;
      pr_error = 1'b0;
   endtask

   task automatic start_request(input logic [31:0] v);
      rd_value = v;
      pr_request_pending = 1'b1;
      @(negedge clk);
      pr_request_pending = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, pr_req_valid, drain_busy} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
            {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, pr_req_valid, drain_busy});
      end
      checks++;
      if (pr_req_data !== 32'h0 || m_axi_wdata !== 32'h0 || drain_count !== 16'h0) begin
         errors++; $display("FAIL reset_data: req=%h wdata=%h count=%h expected all 0", pr_req_data, m_axi_wdata, drain_count);
      end
      checks++;
      if (m_axi_araddr !== 4'h0 || m_axi_awaddr !== 2'h0) begin
         errors++; $display("FAIL reset_addr: araddr=%h awaddr=%h expected 0/0", m_axi_araddr, m_axi_awaddr);
      end
      tick(3);
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (drain_busy !== 1'b0 || m_axi_arvalid !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b arvalid=%b expected 0/0", drain_busy, m_axi_arvalid);
      end
   endtask

   task automatic test_basic;
      int b0, aw0;
      bit ok;
      logic [31:0] got;
      b0 = b_hs; aw0 = aw_hs;
      exp_q.push_back(32'h0000_0012);
      rd_value = 32'h8000_0012;
      pr_request_pending = 1'b1;
      @(negedge clk);
      pr_request_pending = 1'b0;   // falling mid-sequence must not matter
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 4'h0) begin
         errors++; $display("FAIL basic_ar: arvalid=%b araddr=%h expected 1/0", m_axi_arvalid, m_axi_araddr);
      end
      @(negedge clk);
      checks++;
      if (m_axi_rready !== 1'b1) begin
         errors++; $display("FAIL basic_rready: got %b expected 1", m_axi_rready);
      end
      @(negedge clk);
      checks++;
      if (pr_req_valid !== 1'b1) begin
         errors++; $display("FAIL basic_latency: pr_req_valid=%b expected 1 three cycles after pending", pr_req_valid);
      end
      checks++;
      if (pr_req_data !== 32'h0000_0012) begin
         errors++; $display("FAIL basic_req_data: got %h expected 00000012", pr_req_data);
      end
      tick(10);
      pulse_done(1'b0);
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
         errors++; $display("FAIL basic_aw_w: awvalid=%b wvalid=%b expected 1/1", m_axi_awvalid, m_axi_wvalid);
      end
      wait_b(b0, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL basic_b_timeout: no write response within bound, expected one");
      end
      checks++;
      if (drain_count !== 16'd1 || aw_hs - aw0 != 1 || last_awaddr !== 2'h0) begin
         errors++; $display("FAIL basic_count: count=%0d aw=%0d awaddr=%h expected 1/1/0", drain_count, aw_hs - aw0, last_awaddr);
      end
      checks++;
      if (obs_q.size() == 0) begin
         errors++; $display("FAIL basic_wdata: no write data observed, expected %h", exp_q[0]);
      end else begin
         got = obs_q.pop_front();
         if (got !== exp_q[0]) begin
            errors++; $display("FAIL basic_wdata: got %h expected %h", got, exp_q[0]);
         end
      end
      void'(exp_q.pop_front());
      checks++;
      if (drain_busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle: drain_busy=%b expected 0", drain_busy);
      end
   endtask

   task automatic test_spurious;
      int pv0, aw0, ar0;
      pv0 = pv_cyc; aw0 = aw_cyc; ar0 = ar_hs;
      start_request(32'h0000_0007);
      tick(6);
      checks++;
      if (pv_cyc != pv0 || aw_cyc != aw0 || ar_hs - ar0 != 1) begin
         errors++; $display("FAIL spurious_traffic: pr_valid=%0d aw=%0d ar=%0d expected 0/0/1", pv_cyc - pv0, aw_cyc - aw0, ar_hs - ar0);
      end
      checks++;
      if (drain_busy !== 1'b0 || drain_count !== 16'd1 || pr_req_data !== 32'h0000_0007) begin
         errors++; $display("FAIL spurious_state: busy=%b count=%0d req=%h expected 0/1/00000007", drain_busy, drain_count, pr_req_data);
      end
   endtask

   task automatic test_write_delays;
      int aw0, w0, awh0, wh0, b0;
      bit ok;
      logic [31:0] got;
      aw_delay = 3; w_delay = 1;
      start_request(32'h8000_0033);
      wait_pr_valid(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL delay_dispatch: pr_req_valid not seen, expected 1");
      end
      aw0 = aw_cyc; w0 = w_cyc; awh0 = aw_hs; wh0 = w_hs; b0 = b_hs;
      tick(1);
      pulse_done(1'b0);
      wait_b(b0, ok);
      checks++;
      if (!ok || aw_cyc - aw0 != 4 || w_cyc - w0 != 2) begin
         errors++; $display("FAIL delay_valid_len: ok=%0d awvalid=%0d wvalid=%0d cycles expected 1/4/2", ok, aw_cyc - aw0, w_cyc - w0);
      end
      checks++;
      if (aw_hs - awh0 != 1 || w_hs - wh0 != 1 || b_hs - b0 != 1 || drain_count !== 16'd2) begin
         errors++; $display("FAIL delay_one_write: aw=%0d w=%0d b=%0d count=%0d expected 1/1/1/2", aw_hs - awh0, w_hs - wh0, b_hs - b0, drain_count);
      end
      checks++;
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      if (got !== 32'h0000_0033) begin
         errors++; $display("FAIL delay_wdata: got %h expected 00000033", got);
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_error;
      int b0;
      bit ok;
      logic [31:0] got;
      b0 = b_hs;
      exp_q.push_back(32'h8000_00A5);
      start_request(32'h8000_00A5);
      wait_pr_valid(ok);
      tick(2);
      pulse_done(1'b1);
      wait_b(b0, ok);
      checks++;
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      if (!ok || got !== exp_q[0] || drain_count !== 16'd3) begin
         errors++; $display("FAIL error_wdata: ok=%0d got %h count=%0d expected 1/%h/3", ok, got, drain_count, exp_q[0]);
      end
      void'(exp_q.pop_front());
   endtask

   task automatic test_done_in_dispatch;
      int b0;
      bit ok;
      logic [31:0] got;
      b0 = b_hs;
      pr_req_ready = 1'b0;
      start_request(32'h8000_0044);
      wait_pr_valid(ok);
      tick(2);
      checks++;
      if (!ok || pr_req_valid !== 1'b1) begin
         errors++; $display("FAIL dispatch_hold: ok=%0d pr_req_valid=%b expected held 1", ok, pr_req_valid);
      end
      pr_req_ready = 1'b1;
      pr_done = 1'b1;
      @(negedge clk);
      pr_done = 1'b0;
      checks++;
      if (m_axi_awvalid !== 1'b1 || m_axi_wdata !== 32'h0000_0044) begin
         errors++; $display("FAIL dispatch_done: awvalid=%b wdata=%h expected 1/00000044", m_axi_awvalid, m_axi_wdata);
      end
      wait_b(b0, ok);
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (!ok || got !== 32'h0000_0044 || drain_count !== 16'd4) begin
         errors++; $display("FAIL dispatch_complete: ok=%0d wdata=%h count=%0d expected 1/00000044/4", ok, got, drain_count);
      end
   endtask

   task automatic test_done_ignored;
      int aw0;
      aw0 = aw_cyc;
      pulse_done(1'b1);
      tick(3);
      checks++;
      if (drain_busy !== 1'b0 || aw_cyc != aw0 || drain_count !== 16'd4) begin
         errors++; $display("FAIL idle_done: busy=%b aw=%0d count=%0d expected 0/0/4", drain_busy, aw_cyc - aw0, drain_count);
      end
   endtask

   task automatic test_back_to_back;
      int b0;
      bit ok;
      logic [31:0] got;
      b0 = b_hs;
      rd_value = 32'h8000_0050;
      pr_request_pending = 1'b1;
      wait_pr_valid(ok);
      checks++;
      if (!ok || pr_req_data !== 32'h0000_0050) begin
         errors++; $display("FAIL b2b_first: ok=%0d req=%h expected 1/00000050", ok, pr_req_data);
      end
      rd_value = 32'h8000_0051;
      pulse_done(1'b0);
      wait_b(b0, ok);
      checks++;
      if (!ok || drain_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_gap: ok=%0d busy=%b expected 1/0", ok, drain_busy);
      end
      @(negedge clk);
      checks++;
      if (m_axi_arvalid !== 1'b1) begin
         errors++; $display("FAIL b2b_restart: arvalid=%b expected 1", m_axi_arvalid);
      end
      pr_request_pending = 1'b0;
      b0 = b_hs;
      wait_pr_valid(ok);
      checks++;
      if (!ok || pr_req_data !== 32'h0000_0051) begin
         errors++; $display("FAIL b2b_second: ok=%0d req=%h expected 1/00000051", ok, pr_req_data);
      end
      pulse_done(1'b0);
      wait_b(b0, ok);
      checks++;
      if (!ok || drain_count !== 16'd6 || obs_q.size() != 2) begin
         errors++; $display("FAIL b2b_count: ok=%0d count=%0d writes=%0d expected 1/6/2", ok, drain_count, obs_q.size());
      end
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (got !== 32'h0000_0050) begin
         errors++; $display("FAIL b2b_wdata0: got %h expected 00000050", got);
      end
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (got !== 32'h0000_0051) begin
         errors++; $display("FAIL b2b_wdata1: got %h expected 00000051", got);
      end
   endtask

   task automatic test_reset_mid;
      int b0;
      bit ok;
      logic [31:0] got;
      start_request(32'h8000_0066);
      wait_pr_valid(ok);
      @(negedge clk);
      checks++;
      if (!ok || drain_busy !== 1'b1) begin
         errors++; $display("FAIL rstmid_wait: ok=%0d busy=%b expected 1/1", ok, drain_busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (drain_busy !== 1'b0 || pr_req_data !== 32'h0 || drain_count !== 16'h0 || m_axi_wdata !== 32'h0 ||
          pr_req_valid !== 1'b0 || m_axi_awvalid !== 1'b0 || m_axi_arvalid !== 1'b0) begin
         errors++; $display("FAIL rstmid_values: busy=%b req=%h count=%h wdata=%h expected 0/0/0/0",
            drain_busy, pr_req_data, drain_count, m_axi_wdata);
      end
      tick(2);
      rst_n = 1'b1;
      b0 = b_hs;
      pr_request_pending = 1'b1;
      @(negedge clk);
      pr_request_pending = 1'b0;
      checks++;
      if (m_axi_arvalid !== 1'b1) begin
         errors++; $display("FAIL rstmid_restart: arvalid=%b expected 1", m_axi_arvalid);
      end
      wait_pr_valid(ok);
      pulse_done(1'b0);
      wait_b(b0, ok);
      got = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (!ok || drain_count !== 16'd1 || got !== 32'h0000_0066) begin
         errors++; $display("FAIL rstmid_complete: ok=%0d count=%0d wdata=%h expected 1/1/00000066", ok, drain_count, got);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      pr_request_pending = 1'b0;
      m_axi_arready = 1'b1;
      pr_req_ready  = 1'b1;
      pr_done  = 1'b0;
      pr_error = 1'b0;
      rd_value = '0;
      aw_delay = 0;
      w_delay  = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_spurious();
      test_write_delays();
      test_error();
      test_done_in_dispatch();
      test_done_ignored();
      test_back_to_back();
      test_reset_mid();
      tick(2);
      checks++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         errors++; $display("FAIL leftover_writes: observed=%0d expected=%0d required 0/0", obs_q.size(), exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
